// File: rtl/pv_ctrl_seq_if.sv
// Host command channel for the PV control sequencer.
// A command transfers on a clk posedge where cmd_valid and cmd_ready are both high;
// the host holds cmd_op/cmd_move stable while cmd_valid is high and ready is low.
interface pv_ctrl_seq_if #(
  parameter int UCI_WIDTH = 16
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [UCI_WIDTH-1:0] cmd_move;

  modport master (output cmd_valid, output cmd_op, output cmd_move, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_move, output cmd_ready);
endinterface

// File: rtl/pv_ctrl_seq.sv
// Stages host-pushed UCI moves and, on commit/clear, streams one PV table
// write word per ply (all 2**MAX_DEPTH_LOG2 plies) with optional hold stalls.
module pv_ctrl_seq #(
  parameter int UCI_WIDTH      = 16,
  parameter int MAX_DEPTH_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  pv_ctrl_seq_if.slave            cmd,
  input  logic                    hold,
  output logic [31:0]             pv_ctrl_out,
  output logic                    busy,
  output logic                    done,
  output logic [MAX_DEPTH_LOG2:0] pv_len,
  output logic                    overflow,
  output logic [1:0]              dbg_state
);

  localparam int PLIES = 2 ** MAX_DEPTH_LOG2;
  localparam logic [MAX_DEPTH_LOG2:0]   FULL = (MAX_DEPTH_LOG2 + 1)'(PLIES);
  localparam logic [MAX_DEPTH_LOG2-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_ovf;
  logic [MAX_DEPTH_LOG2-1:0] r_ply;
  logic [MAX_DEPTH_LOG2:0] r_len;
  logic [MAX_DEPTH_LOG2:0] r_lat;
  logic [31:0]             r_out;
  logic [UCI_WIDTH-1:0]    r_buf [PLIES];

  logic                    w_accept;
  logic                    w_push;
  logic                    w_seq;
  logic                    w_issue;
  logic [31:0]             w_word;

  assign w_accept = cmd.cmd_valid && r_ready;
  assign w_push   = w_accept && (cmd.cmd_op == 2'd0);
  assign w_seq    = w_accept && ((cmd.cmd_op == 2'd1) || (cmd.cmd_op == 2'd2));
  assign w_issue  = (r_state == S_WRITE) && !hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_seq) w_next = S_WRITE;
      S_WRITE: if (w_issue && (r_ply == LAST)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Plies at or beyond the latched length are written as invalid, zero entries.
  always_comb begin
    w_word                              = '0;
    w_word[31]                          = 1'b1;
    w_word[UCI_WIDTH +: MAX_DEPTH_LOG2] = r_ply;
    if ({1'b0, r_ply} < r_lat) begin
      w_word[UCI_WIDTH-1:0]            = r_buf[r_ply];
      w_word[UCI_WIDTH+MAX_DEPTH_LOG2] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ply   <= '0;
      r_len   <= '0;
      r_lat   <= '0;
      r_out   <= '0;
    end else begin
      // Ready drops on the same edge a commit/clear is taken, so nothing slips in behind it.
      r_ready <= (r_state == S_IDLE) && !w_seq;
      r_done  <= (r_state == S_DONE);
      r_out   <= w_issue ? w_word : '0;
      if (w_push) begin
        if (r_len == FULL) r_ovf <= 1'b1;
        else               r_len <= r_len + 1'b1;
      end
      if (w_seq) begin
        r_ply <= '0;
        if (cmd.cmd_op == 2'd1) begin
          r_lat <= r_len;
        end else begin
          r_lat <= '0;
          r_ovf <= 1'b0;
        end
      end
      if (w_issue && (r_ply != LAST)) r_ply <= r_ply + 1'b1;
      if (r_state == S_DONE) r_len <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && (r_len != FULL)) r_buf[r_len[MAX_DEPTH_LOG2-1:0]] <= cmd.cmd_move;
  end

  assign cmd.cmd_ready = r_ready;
  assign pv_ctrl_out   = r_out;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign pv_len        = r_len;
  assign overflow      = r_ovf;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_pv_ctrl_seq.sv
// Directed bench for pv_ctrl_seq with UCI_WIDTH=16, MAX_DEPTH_LOG2=3 (8 plies).
module tb_pv_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [31:0] pv_ctrl_out;
  logic        busy;
  logic        done;
  logic [3:0]  pv_len;
  logic        overflow;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_e [8];

  pv_ctrl_seq_if #(.UCI_WIDTH(16)) cmd_if ();

  pv_ctrl_seq #(.UCI_WIDTH(16), .MAX_DEPTH_LOG2(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .hold        (hold),
    .pv_ctrl_out (pv_ctrl_out),
    .busy        (busy),
    .done        (done),
    .pv_len      (pv_len),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // strobe | entry_valid@19 | ply@18:16 | entry@15:0
  function automatic logic [31:0] word(input int p, input bit v, input logic [15:0] e);
    logic [31:0] w;
    w = 32'h8000_0000 | {16'h0, e};
    w = w | ({29'h0, p[2:0]} << 16);
    if (v) w = w | 32'h0008_0000;
    return w;
  endfunction

  task automatic send(input logic [1:0] op, input logic [15:0] mv);
    int cnt;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_move  = mv;
    cnt = 0;
    while (!cmd_if.cmd_ready && cnt < 50) begin
      step();
      cnt++;
    end
    chk("send_ready", {31'h0, cmd_if.cmd_ready}, 32'h1);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Called right after the accepting edge of a commit/clear; plies follow on consecutive edges.
  task automatic expect_seq(input int nv);
    for (int p = 0; p < 8; p++) begin
      step();
      chk($sformatf("ply%0d", p), pv_ctrl_out, word(p, p < nv, (p < nv) ? exp_e[p] : 16'h0));
      chk("busy_w", {31'h0, busy}, 32'h1);
      chk("done_w", {31'h0, done}, 32'h0);
      chk("ready_w", {31'h0, cmd_if.cmd_ready}, 32'h0);
    end
    step();
    chk("done_hi", {31'h0, done}, 32'h1);
    chk("done_out", pv_ctrl_out, 32'h0);
    chk("done_len", {28'h0, pv_len}, 32'h0);
    step();
    chk("done_lo", {31'h0, done}, 32'h0);
    chk("ready_back", {31'h0, cmd_if.cmd_ready}, 32'h1);
    chk("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset            = 1'b1;
    hold             = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_move  = 16'h0;
    #1;
    chk("rst_out", pv_ctrl_out, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, cmd_if.cmd_ready}, 32'h0);
    chk("rst_len", {28'h0, pv_len}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    step();
    step();
    reset = 1'b0;
    chk("ready_pre", {31'h0, cmd_if.cmd_ready}, 32'h0);
    step();
    chk("ready_post", {31'h0, cmd_if.cmd_ready}, 32'h1);

    // Three moves then commit
    send(2'd0, 16'h1234);
    send(2'd0, 16'h0C1C);
    send(2'd0, 16'h3355);
    chk("len3", {28'h0, pv_len}, 32'h3);
    exp_e[0] = 16'h1234; exp_e[1] = 16'h0C1C; exp_e[2] = 16'h3355;
    send(2'd1, 16'h0);
    expect_seq(3);

    // Reserved op is a no-op
    send(2'd3, 16'hFFFF);
    step();
    chk("op3_busy", {31'h0, busy}, 32'h0);
    chk("op3_out", pv_ctrl_out, 32'h0);
    chk("op3_len", {28'h0, pv_len}, 32'h0);

    // Overflow: 9 pushes, commit of 8, empty commit keeps overflow, clear drops it
    for (int i = 0; i < 9; i++) begin
      send(2'd0, 16'h0100 + 16'(i));
      if (i == 7) chk("ovf_at8", {31'h0, overflow}, 32'h0);
    end
    chk("len_full", {28'h0, pv_len}, 32'h8);
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 8; i++) exp_e[i] = 16'h0100 + 16'(i);
    send(2'd1, 16'h0);
    expect_seq(8);
    chk("ovf_keep1", {31'h0, overflow}, 32'h1);
    send(2'd1, 16'h0);
    expect_seq(0);
    chk("ovf_keep2", {31'h0, overflow}, 32'h1);
    send(2'd2, 16'h0);
    chk("ovf_clr", {31'h0, overflow}, 32'h0);
    expect_seq(0);

    // Hold: ignored in IDLE, then stalls the ply-1 write for 3 cycles
    hold = 1'b1;
    send(2'd0, 16'hAAAA);
    hold = 1'b0;
    send(2'd0, 16'hBBBB);
    chk("len2", {28'h0, pv_len}, 32'h2);
    send(2'd1, 16'h0);
    step();
    chk("h_ply0", pv_ctrl_out, word(0, 1'b1, 16'hAAAA));
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("h_zero", pv_ctrl_out, 32'h0);
      chk("h_busy", {31'h0, busy}, 32'h1);
    end
    hold = 1'b0;
    for (int p = 1; p < 8; p++) begin
      step();
      chk($sformatf("h_ply%0d", p), pv_ctrl_out,
          word(p, p == 1, (p == 1) ? 16'hBBBB : 16'h0));
      chk("h_done_lo", {31'h0, done}, 32'h0);
    end
    step();
    chk("h_done", {31'h0, done}, 32'h1);

    // Push presented during WRITE waits until IDLE
    step();
    send(2'd0, 16'h1111);
    exp_e[0] = 16'h1111;
    send(2'd1, 16'h0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_move  = 16'h2222;
    expect_seq(1);
    step();
    cmd_if.cmd_valid = 1'b0;
    chk("late_push", {28'h0, pv_len}, 32'h1);

    // Reset in the middle of the ply-4 write
    send(2'd0, 16'h0A0A);
    send(2'd0, 16'h0B0B);
    send(2'd0, 16'h0C0C);
    exp_e[0] = 16'h2222; exp_e[1] = 16'h0A0A; exp_e[2] = 16'h0B0B; exp_e[3] = 16'h0C0C;
    send(2'd1, 16'h0);
    for (int p = 0; p < 5; p++) begin
      step();
      chk($sformatf("r_ply%0d", p), pv_ctrl_out, word(p, p < 4, (p < 4) ? exp_e[p] : 16'h0));
    end
    #3;
    reset = 1'b1;
    #1;
    chk("mid_out", pv_ctrl_out, 32'h0);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_len", {28'h0, pv_len}, 32'h0);
    chk("mid_ready", {31'h0, cmd_if.cmd_ready}, 32'h0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("post_rst_strobe", {31'h0, pv_ctrl_out[31]}, 32'h0);
      chk("post_rst_busy", {31'h0, busy}, 32'h0);
    end
    chk("post_rst_ready", {31'h0, cmd_if.cmd_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pv_ctrl_seq.md
PV_CTRL_SEQ -- requirements
Module: pv_ctrl_seq

Interface
REQ-001 SHALL have parameter UCI_WIDTH, default 16: width of one UCI move entry.
REQ-002 SHALL have parameter MAX_DEPTH_LOG2, default 6: ply index width. Plies = 2**MAX_DEPTH_LOG2. Legal only when UCI_WIDTH+MAX_DEPTH_LOG2+1 <= 31.
REQ-003 SHALL have port clk, input, 1 bit: the only clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: host command present.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high at a posedge.
REQ-007 SHALL have port cmd_op, input, 2 bits: 0 = push move, 1 = commit, 2 = clear all, 3 = reserved.
REQ-008 SHALL have port cmd_move, input, UCI_WIDTH bits: move for push.
REQ-009 SHALL have port hold, input, 1 bit: stall table writes, e.g. while a board evaluation is in flight.
REQ-010 SHALL have port pv_ctrl_out, output, 32 bits: registered PV table write word.
REQ-011 SHALL have port busy, output, 1 bit: sequencer not idle.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a commit or clear completes.
REQ-013 SHALL have port pv_len, output, MAX_DEPTH_LOG2+1 bits: number of staged moves.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, set when a push is dropped.

Function
REQ-015 pv_ctrl_out fields SHALL be:
- [UCI_WIDTH-1:0]: entry.
- [UCI_WIDTH +: MAX_DEPTH_LOG2]: ply.
- [UCI_WIDTH+MAX_DEPTH_LOG2]: entry_valid.
- [31]: write strobe.
- All other bits: 0.
REQ-016 Staging buffer SHALL hold 2**MAX_DEPTH_LOG2 moves. A push writes cmd_move at index pv_len, then pv_len increments.
REQ-017 A push when pv_len == 2**MAX_DEPTH_LOG2 SHALL be accepted and discarded: pv_len unchanged, overflow <= 1.
REQ-018 States SHALL be IDLE, WRITE and DONE. cmd_ready = 1 only in IDLE. busy = 1 in WRITE and DONE.
REQ-019 IDLE transitions:
- Accepted commit -> WRITE; ply counter <= 0; latched length <= pv_len.
- Accepted clear -> WRITE; latched length <= 0; overflow <= 0.
- Push and op 3 stay in IDLE. Op 3 has no effect.
REQ-020 Each WRITE cycle with hold = 0 SHALL register exactly one write word:
- strobe = 1, ply = counter.
- If counter < latched length: entry = staged[counter], entry_valid = 1.
- Otherwise: entry = 0, entry_valid = 0.
- Counter then increments.
REQ-021 A WRITE cycle with hold = 1 SHALL register pv_ctrl_out = 0 and hold the counter. hold has no effect outside WRITE.
REQ-022 After the write for ply 2**MAX_DEPTH_LOG2-1 is issued, the state SHALL move to DONE. No counter wrap is permitted.
REQ-023 DONE SHALL last one cycle: done = 1, pv_len <= 0, then IDLE. The staged data is retained but is no longer counted.
REQ-024 Latency with hold low: command accepted at edge T -> ply-0 strobe visible after T+1 -> last strobe after T+2**MAX_DEPTH_LOG2 -> done after T+2**MAX_DEPTH_LOG2+1 -> cmd_ready high after T+2**MAX_DEPTH_LOG2+2.
REQ-025 pv_ctrl_out[31] SHALL be 0 in every cycle outside WRITE, including the DONE cycle.
REQ-026 A commit with pv_len = 0 SHALL behave as a clear, except that overflow is not cleared.

Reset
REQ-027 While reset is high, asynchronously and regardless of state, the block SHALL hold:
- State = IDLE.
- pv_ctrl_out = 0, done = 0, busy = 0.
- cmd_ready = 0; it returns to 1 on the first clk edge after reset deasserts.
- pv_len = 0, overflow = 0, ply counter = 0.
REQ-028 A reset during WRITE SHALL abandon the sequence with no further strobes. The downstream PV table state is then undefined, and the host re-issues clear or commit.
REQ-029 Staging buffer contents need no reset.

Verification (UCI_WIDTH = 16, MAX_DEPTH_LOG2 = 3, 8 plies)
REQ-030 Push 0x1234, 0x0C1C, 0x3355; commit; hold low -> 8 consecutive strobes:
- Plies 0-2 valid with those entries.
- Plies 3-7 entry_valid = 0, entry = 0.
- done is high in the cycle after ply 7; pv_len = 0 afterwards.
REQ-031 Push 9 moves -> pv_len = 8, overflow = 1. The 9th move never appears in any write. A subsequent clear writes 8 invalid plies and sets overflow = 0.
REQ-032 Commit with 2 staged moves; hold high for 3 cycles starting at the ply-1 write -> pv_ctrl_out = 0 for those 3 cycles. Plies then resume at 1 with no skip or duplicate. done is delayed by exactly 3 cycles.
REQ-033 Assert cmd_valid with a push during WRITE -> cmd_ready = 0 and the push is not taken. The same push is accepted in the first IDLE cycle after done, and pv_len becomes 1.
REQ-034 Assert reset during the ply-4 write, mid-clock -> pv_ctrl_out = 0, busy = 0 and pv_len = 0 immediately. No strobes occur after reset release until a new command is accepted.
